parking_entry_frontend: RTL and testbench
=========================================

# parking_entry_frontend

Front-end conditioning stage in front of the parking gate controller. Filters the raw entrance and exit loop sensors into clean, debounced levels with one-cycle edge pulses. Assembles a two-digit password from a serial 2-bit keypad into the `password_1`/`password_2` pair the gate controller compares. Digits are presented only once both are entered, so a partial entry never matches.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized samples a raw sensor must hold a new level before the debounced output follows (legal range 2–255).
- `ENTRY_TIMEOUT`, 64: idle cycles after the first digit before a half-entered password is discarded (legal range 2–65535).
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `raw_entrance` in 1: asynchronous entrance loop sensor, active high.
- `raw_exit` in 1: asynchronous exit loop sensor, active high.
- `key_value` in 2: keypad digit, valid when `key_strobe`=1.
- `key_strobe` in 1: synchronous one-cycle digit-entered pulse.
- `key_clear` in 1: synchronous; discards any entry.
- `sensor_entrance` out 1: debounced entrance level.
- `sensor_exit` out 1: debounced exit level.
- `entry_pulse` out 1: one cycle on debounced entrance rise.
- `exit_pulse` out 1: one cycle on debounced exit rise.
- `password_1` out 2: first digit; 2'b00 unless `pass_valid`.
- `password_2` out 2: second digit; 2'b00 unless `pass_valid`.
- `pass_valid` out 1: both digits captured and presented.

## Operation
**Sensor channel (two identical instances)**
- Two-flop synchronizer, then a stability counter.
- Counter clears whenever the synchronized sample equals the current debounced level; otherwise it increments.
- When the count reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` samples leaves the output unchanged.
- A rising debounced transition asserts the pulse for exactly one cycle. A falling transition produces no pulse.

**Keypad FSM**
- States: EMPTY, ONE, FULL. Internal digit registers `d1`, `d2`.
- EMPTY:
  - `key_strobe` → `d1`=`key_value`, go to ONE, idle counter cleared.
- ONE:
  - `key_strobe` → `d2`=`key_value`, go to FULL.
  - Otherwise the idle counter increments; when it reaches `ENTRY_TIMEOUT` → EMPTY.
- FULL:
  - Outputs present `d1`/`d2` and `pass_valid`=1; held indefinitely.
  - `key_strobe` → restart: `d1`=`key_value`, `d2`=0, go to ONE.
  - `exit_pulse` → EMPTY (the car has left; its password is consumed).
- Any state: `key_clear` → EMPTY, `d1`=`d2`=0.
- Priority, highest first: `key_clear`, `exit_pulse` (FULL only), `key_strobe`, timeout.
- Outputs are registered from state: `pass_valid` = (state==FULL); password outputs are gated to 2'b00 when not FULL.

## Timing
- Reset (asynchronous assert, synchronous deassert by design): every output is 0. Synchronizers, counters and digit registers are 0; FSM is in EMPTY.
- Sensor latency: a raw edge held steady appears on `sensor_*` after 2 (synchronizer) + `DEBOUNCE_CYCLES` rising edges, ±1 for raw-edge phase. The pulse is coincident with the level change.
- Keypad: `pass_valid` and the digit outputs go high on the edge after the clock that samples the second `key_strobe`.
- A strobe in ONE on the same cycle the idle counter hits `ENTRY_TIMEOUT` is accepted (strobe wins) → FULL.
- Idle counter width is `$clog2(ENTRY_TIMEOUT+1)`; it saturates and never wraps.
- Simultaneous `exit_pulse` and `key_strobe` in FULL → EMPTY; the strobe is dropped.
- Reset asserted mid-entry or mid-debounce: immediate return to reset values; no pulse is emitted on reset release even if raw sensors are high. The level is then re-qualified through the full debounce.

## Test plan
- Reset with `raw_entrance`=1 held → `sensor_entrance` rises exactly 2+4 cycles after `reset_n` release with one `entry_pulse`; all outputs are 0 during reset.
- `raw_exit` glitch high for 3 cycles (`DEBOUNCE_CYCLES`=4) → `sensor_exit` and `exit_pulse` stay 0. A hold of 4+ cycles → one pulse, level high.
- Strobes 2'b01 then 2'b10 → `password_1`=01, `password_2`=10, `pass_valid`=1 one cycle after the second strobe. The outputs read 00/00 while in ONE.
- Strobe 2'b01, then 64 idle cycles → FSM returns to EMPTY. A subsequent single strobe 2'b10 leaves `pass_valid`=0.
- FULL with 01/10, then `raw_exit` debounced high → `exit_pulse` drops `pass_valid` and both passwords to 0 the next cycle. Repeat with `key_clear` and `key_strobe` in the same cycle → EMPTY, digit ignored.
- Reset pulsed while in ONE → all outputs 0 immediately. The next two strobes form a fresh password.

Source files
------------

// File: rtl/parking_entry_frontend_if.sv
// ============================================================================
// Module      : parking_entry_frontend_if
// Description : Sensor, keypad and password signal bundle for the entry front end.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface parking_entry_frontend_if;
  logic       raw_entrance;
  logic       raw_exit;
  logic [1:0] key_value;
  logic       key_strobe;
  logic       key_clear;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic       entry_pulse;
  logic       exit_pulse;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       pass_valid;

  modport master (
    output raw_entrance, raw_exit, key_value, key_strobe, key_clear,
    input  sensor_entrance, sensor_exit, entry_pulse, exit_pulse,
           password_1, password_2, pass_valid
  );

  modport slave (
    input  raw_entrance, raw_exit, key_value, key_strobe, key_clear,
    output sensor_entrance, sensor_exit, entry_pulse, exit_pulse,
           password_1, password_2, pass_valid
  );
endinterface

`default_nettype wire

// File: rtl/parking_entry_frontend.sv
// ============================================================================
// Module      : parking_entry_frontend
// Description : Loop-sensor debouncers plus two-digit keypad password assembler.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module parking_entry_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ENTRY_TIMEOUT   = 64
) (
  input wire logic clk,
  input wire logic reset_n,
  parking_entry_frontend_if.slave bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IW = $clog2(ENTRY_TIMEOUT + 1);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] pulse;

  assign raw = {bus.raw_exit, bus.raw_entrance};

  // Channel 0 is the entrance loop, channel 1 the exit loop.
  for (genvar g = 0; g < 2; g++) begin : g_sensor
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          pulse_q;
    logic          differ;
    logic          settle;

    always_comb begin
      differ = (sync_q[1] != level_q);
      settle = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q  <= 2'b00;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], raw[g]};
        if (!differ || settle) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        level_q <= level_q ^ settle;
        pulse_q <= settle & ~level_q;
      end
    end

    assign level[g] = level_q;
    assign pulse[g] = pulse_q;
  end

  logic [1:0]    state_q, state_d;
  logic [1:0]    d1_q, d1_d;
  logic [1:0]    d2_q, d2_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [IW-1:0] idle_inc;
  logic          pass_valid;
  logic [1:0]    pw1;
  logic [1:0]    pw2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      d1_q    <= 2'b00;
      d2_q    <= 2'b00;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      idle_q  <= idle_d;
    end
  end

  // Idle counter saturates at the timeout value rather than wrapping.
  assign idle_inc = (idle_q == IW'(ENTRY_TIMEOUT)) ? idle_q : idle_q + IW'(1);

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    idle_d  = idle_q;
    if (bus.key_clear) begin
      state_d = S_EMPTY;
      d1_d    = 2'b00;
      d2_d    = 2'b00;
      idle_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (bus.key_strobe) begin
            d1_d    = bus.key_value;
            idle_d  = '0;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (bus.key_strobe) begin
            d2_d    = bus.key_value;
            state_d = S_FULL;
          end else if (idle_inc == IW'(ENTRY_TIMEOUT)) begin
            idle_d  = '0;
            state_d = S_EMPTY;
          end else begin
            idle_d  = idle_inc;
          end
        end
        S_FULL: begin
          if (pulse[1]) begin
            state_d = S_EMPTY;
          end else if (bus.key_strobe) begin
            d1_d    = bus.key_value;
            d2_d    = 2'b00;
            idle_d  = '0;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    pass_valid = (state_q == S_FULL);
    pw1        = pass_valid ? d1_q : 2'b00;
    pw2        = pass_valid ? d2_q : 2'b00;
  end

  assign bus.sensor_entrance = level[0];
  assign bus.sensor_exit     = level[1];
  assign bus.entry_pulse     = pulse[0];
  assign bus.exit_pulse      = pulse[1];
  assign bus.pass_valid      = pass_valid;
  assign bus.password_1      = pw1;
  assign bus.password_2      = pw2;

endmodule

`default_nettype wire

// File: tb/tb_parking_entry_frontend.sv
// ============================================================================
// Module      : tb_parking_entry_frontend
// Description : Directed vector bench for the parking entry front end.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parking_entry_frontend;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  parking_entry_frontend_if bus ();

  parking_entry_frontend #(
    .DEBOUNCE_CYCLES(4),
    .ENTRY_TIMEOUT  (64)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       stb;
    logic [1:0] val;
    logic       clr;
    logic       valid;
    logic [1:0] p1;
    logic [1:0] p2;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key(input logic [1:0] v);
    bus.key_value  = v;
    bus.key_strobe = 1'b1;
    step();
    bus.key_strobe = 1'b0;
  endtask

  task automatic clear_entry();
    bus.key_clear = 1'b1;
    step();
    bus.key_clear = 1'b0;
  endtask

  function automatic logic [8:0] all_out();
    return {bus.sensor_entrance, bus.sensor_exit, bus.entry_pulse, bus.exit_pulse,
            bus.pass_valid, bus.password_1, bus.password_2};
  endfunction

  function automatic logic [4:0] pw_out();
    return {bus.pass_valid, bus.password_1, bus.password_2};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {stb, val, clr, valid, p1, p2}
    vecs[0]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b01, 2'b10};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 2'b10};
    vecs[4]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[5]  = '{1'b1, 2'b00, 1'b0, 1'b1, 2'b11, 2'b00};
    vecs[6]  = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 1'b1, 2'b10, 2'b01};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00};

    bus.raw_entrance = 1'b1;
    bus.raw_exit     = 1'b0;
    bus.key_value    = 2'b00;
    bus.key_strobe   = 1'b0;
    bus.key_clear    = 1'b0;

    // Reset with entrance held high, then exact debounce latency.
    repeat (3) @(negedge clk);
    chk("reset_outputs", 16'(all_out()), 16'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("ent_level", 16'(bus.sensor_entrance), 16'(k >= 6));
      chk("ent_pulse", 16'(bus.entry_pulse), 16'(k == 6));
    end

    // Keypad vector table.
    for (int i = 0; i < 11; i++) begin
      bus.key_strobe = vecs[i].stb;
      bus.key_value  = vecs[i].val;
      bus.key_clear  = vecs[i].clr;
      step();
      chk($sformatf("vec%0d", i), 16'(pw_out()),
          16'({vecs[i].valid, vecs[i].p1, vecs[i].p2}));
    end
    bus.key_strobe = 1'b0;
    bus.key_clear  = 1'b0;

    // Exit glitch of three samples must be rejected.
    bus.raw_exit = 1'b1;
    repeat (3) step();
    bus.raw_exit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("glitch_level", 16'(bus.sensor_exit), 16'h0);
      chk("glitch_pulse", 16'(bus.exit_pulse), 16'h0);
    end

    // FULL, then a debounced exit consumes the password.
    key(2'b01);
    key(2'b10);
    chk("full_before_exit", 16'(pw_out()), 16'b1_01_10);
    bus.raw_exit = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("exit_level", 16'(bus.sensor_exit), 16'(k >= 6));
      chk("exit_pulse", 16'(bus.exit_pulse), 16'(k == 6));
      chk("exit_valid", 16'(bus.pass_valid), 16'(k <= 6));
    end
    chk("exit_pw_cleared", 16'(pw_out()), 16'h0);
    bus.raw_exit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fall_no_pulse", 16'(bus.exit_pulse), 16'h0);
    end
    chk("exit_fell", 16'(bus.sensor_exit), 16'h0);

    // Exit pulse and strobe together in FULL: strobe is dropped.
    key(2'b01);
    key(2'b10);
    bus.raw_exit = 1'b1;
    repeat (6) step();
    chk("exit_pulse_sync", 16'(bus.exit_pulse), 16'h1);
    key(2'b11);
    chk("exit_beats_strobe", 16'(pw_out()), 16'h0);
    key(2'b01);
    chk("strobe_was_dropped", 16'(pw_out()), 16'h0);
    bus.raw_exit = 1'b0;
    repeat (8) step();
    clear_entry();

    // Strobe on the cycle the idle counter reaches the timeout wins.
    key(2'b01);
    repeat (63) step();
    key(2'b10);
    chk("timeout_edge_strobe", 16'(pw_out()), 16'b1_01_10);
    clear_entry();

    // Full timeout discards the half-entered password.
    key(2'b01);
    repeat (64) step();
    key(2'b10);
    chk("timeout_discard", 16'(pw_out()), 16'h0);
    clear_entry();

    // Asynchronous reset while in ONE, then a fresh password.
    key(2'b01);
    chk("one_outputs", 16'(pw_out()), 16'h0);
    chk("ent_still_high", 16'(bus.sensor_entrance), 16'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 16'(all_out()), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    key(2'b10);
    chk("post_reset_no_pulse_a", 16'(bus.entry_pulse), 16'h0);
    key(2'b11);
    chk("post_reset_no_pulse_b", 16'(bus.entry_pulse), 16'h0);
    chk("fresh_password", 16'(pw_out()), 16'b1_10_11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
